// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and TX-side byte handshakes of the shared UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int DATA_W = 8
);
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [DATA_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (
    output req_data, req_last, req_valid, tx_ready,
    input req_ready, tx_data, tx_valid
  );
  modport slave (
    input req_data, req_last, req_valid, tx_ready,
    output req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-level round-robin sharing of one UART TX between N_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to release a LOCK that idles for TIMEOUT_CYC cycles.
module uart_tx_arbiter #(
  parameter int N_REQ = 2,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYC = 50000,
  localparam int GW = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input logic clk,
  input logic btn,
  uart_tx_arbiter_if.slave bus,
  output logic [GW-1:0] grant_id,
  output logic busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic timeout_pulse
`endif
);
  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, LOCK} state_t;
  state_t state;
  logic [GW-1:0] last_grant, winner, idx;
  logic any_valid, hold_last, tx_valid, sel_valid, sel_last;
  logic [DATA_W-1:0] tx_data, sel_data;
  logic [N_REQ-1:0] req_ready;
  if (N_REQ < 1 || N_REQ > 8 || DATA_W < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end
  // Scan farthest-to-nearest from last_grant so the nearest valid requester wins.
  always_comb begin
    winner = last_grant;
    any_valid = 1'b0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % N_REQ);
      if (bus.req_valid[idx]) begin
        winner = idx;
        any_valid = 1'b1;
      end
    end
  end
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    sel_valid = 1'b0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
        sel_last = bus.req_last[i];
        sel_valid = bus.req_valid[i];
        req_ready[i] = state == CAPTURE;
      end
    end
  end
  assign bus.req_ready = req_ready;
  assign bus.tx_data = tx_data;
  assign bus.tx_valid = tx_valid;
  assign busy = state != IDLE;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;
`endif
  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      state <= IDLE;
      tx_valid <= 1'b0;
      tx_data <= '0;
      hold_last <= 1'b0;
      last_grant <= GW'(N_REQ - 1);
      grant_id <= GW'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      cnt <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
      cnt <= state == LOCK ? cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: if (any_valid) begin
          grant_id <= winner;
          state <= CAPTURE;
        end
        CAPTURE: if (sel_valid) begin
          tx_data <= sel_data;
          hold_last <= sel_last;
          tx_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (bus.tx_ready) begin
          tx_valid <= 1'b0;
          if (hold_last) begin
            last_grant <= grant_id;
            state <= IDLE;
          end else state <= LOCK;
        end
        LOCK:
`ifdef UART_ARB_TIMEOUT_EN
          if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            last_grant <= grant_id;
            timeout_pulse <= 1'b1;
            state <= IDLE;
          end else
`endif
          if (sel_valid) state <= CAPTURE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N = 2;
  localparam int W = 8;
  logic clk = 1'b0;
  logic btn = 1'b0;
  logic [0:0] grant_id;
  logic busy;
  int n_chk = 0;
  int n_err = 0;
  logic [8:0] dq[N][$];
  logic [11:0] exp_q[$];
  int obs_id[$];
  logic [7:0] obs_d[$];
  int obs_c[$];
  int first_acc[N];
  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus();
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 16;
  logic timeout_pulse;
  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .btn(btn), .bus(bus), .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );
`else
  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .btn(btn), .bus(bus), .grant_id(grant_id), .busy(busy)
  );
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input bit v, input logic [7:0] d, input bit l);
    bus.req_valid[i] = v;
    bus.req_data[i*W +: W] = d;
    bus.req_last[i] = l;
  endtask
  task automatic do_reset();
    btn = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_ready = 1'b0;
    cyc();
    cyc();
    btn = 1'b1;
  endtask
  // Model: whole messages go out in round-robin order among requesters that still hold messages.
  task automatic run(input int budget, input bit rnd);
    logic [8:0] cq[N][$];
    logic [8:0] x;
    logic [11:0] e;
    logic [7:0] sd;
    int last, id, c;
    bit stall;
    exp_q.delete();
    obs_id.delete();
    obs_d.delete();
    obs_c.delete();
    for (int i = 0; i < N; i++) begin
      cq[i] = dq[i];
      first_acc[i] = -1;
    end
    last = N - 1;
    while (1) begin
      id = -1;
      for (int k = N; k >= 1; k--) if (cq[(last + k) % N].size() > 0) id = (last + k) % N;
      if (id < 0) break;
      do begin
        x = cq[id].pop_front();
        exp_q.push_back({3'(id), x});
      end while (!x[8]);
      last = id;
    end
    c = 0;
    stall = 1'b0;
    sd = '0;
    while (exp_q.size() > 0 && c < budget) begin
      for (int i = 0; i < N; i++)
        if (dq[i].size() > 0) drive(i, 1'b1, dq[i][0][7:0], dq[i][0][8]);
        else drive(i, 1'b0, 8'h00, 1'b0);
      bus.tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall) check("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, sd});
      stall = bus.tx_valid && !bus.tx_ready;
      sd = bus.tx_data;
      if (bus.req_ready != '0) check("ready_onehot", 32'($onehot(bus.req_ready)), 1);
      if (bus.tx_valid && bus.tx_ready) begin
        e = exp_q.pop_front();
        check("tx_data", bus.tx_data, e[7:0]);
        check("tx_owner", grant_id, e[11:9]);
        obs_id.push_back(int'(grant_id));
        obs_d.push_back(bus.tx_data);
        obs_c.push_back(c);
      end
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          void'(dq[i].pop_front());
          if (first_acc[i] < 0) first_acc[i] = c;
        end
      cyc();
      c++;
    end
    check("drain_left", exp_q.size(), 0);
    bus.req_valid = '0;
    bus.tx_ready = 1'b1;
    repeat (3) cyc();
  endtask
  initial begin
    int n;
    int pc, r1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_ready = 1'b0;
    do_reset();
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, N - 1);
    drive(0, 1'b1, 8'h41, 1'b1);
    bus.tx_ready = 1'b1;
    cyc();
    check("t1_ready_c1", bus.req_ready, 2'b01);
    check("t1_txv_c1", bus.tx_valid, 0);
    cyc();
    drive(0, 1'b0, 8'h00, 1'b0);
    check("t1_txv_c2", bus.tx_valid, 1);
    check("t1_txd_c2", bus.tx_data, 8'h41);
    check("t1_ready_c2", bus.req_ready, 0);
    cyc();
    check("t1_busy_c3", busy, 0);
    check("t1_grant_c3", grant_id, 0);
    check("t1_txv_c3", bus.tx_valid, 0);
    do_reset();
    for (int i = 0; i < N; i++) dq[i].delete();
    dq[0].push_back(9'h110);
    dq[1].push_back(9'h120);
    run(200, 1'b0);
    check("t2_count", obs_d.size(), 2);
    check("t2_first", obs_d[0], 8'h10);
    check("t2_second", obs_d[1], 8'h20);
    do_reset();
    for (int j = 0; j < 4; j++) begin
      dq[0].push_back({1'b1, 8'(8'h10 + j)});
      dq[1].push_back({1'b1, 8'(8'h20 + j)});
    end
    run(400, 1'b1);
    for (int j = 0; j < 8; j++) check("t2_alternate", obs_id[j], j % 2);
    do_reset();
    dq[0].push_back(9'h0A1);
    dq[0].push_back(9'h0A2);
    dq[0].push_back(9'h1A3);
    dq[1].push_back(9'h1B1);
    run(400, 1'b1);
    check("t3_order", {obs_d[0], obs_d[1], obs_d[2], obs_d[3]}, 32'hA1A2A3B1);
    check("t3_b1_after_a3", first_acc[1] > obs_c[2], 1);
    do_reset();
    drive(0, 1'b1, 8'h5A, 1'b1);
    cyc();
    cyc();
    drive(0, 1'b0, 8'h00, 1'b0);
    for (int j = 0; j < 20; j++) begin
      check("t4_stall", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h5A});
      cyc();
    end
    bus.tx_ready = 1'b1;
    n = 0;
    for (int j = 0; j < 6; j++) begin
      if (bus.tx_valid && bus.tx_ready) n++;
      cyc();
    end
    check("t4_one_transfer", n, 1);
    do_reset();
    drive(0, 1'b1, 8'h55, 1'b1);
    cyc();
    cyc();
    drive(0, 1'b0, 8'h00, 1'b0);
    check("t5_in_send", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h55});
    cyc();
    btn = 1'b0;
    #1;
    check("t5_async_txv", bus.tx_valid, 0);
    check("t5_async_ready", bus.req_ready, 0);
    check("t5_async_busy", busy, 0);
    cyc();
    btn = 1'b1;
    drive(0, 1'b1, 8'h61, 1'b1);
    drive(1, 1'b1, 8'h62, 1'b1);
    cyc();
    check("t5_first_ready", bus.req_ready, 2'b01);
    check("t5_first_grant", grant_id, 0);
`ifdef UART_ARB_TIMEOUT_EN
    do_reset();
    bus.tx_ready = 1'b1;
    drive(0, 1'b1, 8'h77, 1'b0);
    drive(1, 1'b1, 8'h88, 1'b1);
    cyc();
    check("t6_ready0", bus.req_ready, 2'b01);
    cyc();
    drive(0, 1'b0, 8'h00, 1'b0);
    n = 0;
    pc = -1;
    r1 = -1;
    for (int c = 2; c < 40; c++) begin
      if (timeout_pulse) begin
        n++;
        if (pc < 0) pc = c;
      end
      if (bus.req_ready[1] && r1 < 0) r1 = c;
      cyc();
    end
    check("t6_pulse_count", n, 1);
    check("t6_pulse_cycle", pc, 19);
    check("t6_next_grant", r1, 20);
`endif
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        dq[i].delete();
        for (int m = $urandom_range(0, 4); m > 0; m--) begin
          n = $urandom_range(1, 4);
          for (int b = 0; b < n; b++) dq[i].push_back({b == n - 1, 8'($urandom)});
        end
      end
      run(3000, 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
